// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern driver: mode encoding and defaults.
package led_pkg;

  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_SOLID   = 3'd1,
    MODE_BLINK   = 3'd2,
    MODE_CHASE   = 3'd3,
    MODE_BREATHE = 3'd4
  } mode_t;

  localparam int DEFAULT_BREATHE_STEP = 16;

  // Unused encodings 5-7 collapse to OFF so the stored mode is always legal.
  function automatic mode_t decode_mode(input logic [2:0] raw);
    if (raw > 3'd4) return MODE_OFF;
    return mode_t'(raw);
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter and duty compare shared by all LEDs.
// Define LED_GAMMA_EN to apply a registered square-law gamma to the duty.
module led_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty,
  output logic                on
);

  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

`ifdef LED_GAMMA_EN
  logic [PWM_BITS-1:0] duty_g;
  logic                force_on;

  // Force-on is decided on the linear duty, delayed to stay aligned with duty_g.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_g   <= '0;
      force_on <= 1'b0;
    end else begin
      duty_g   <= PWM_BITS'(({{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty}) >> PWM_BITS);
      force_on <= &duty;
    end
  end

  assign on = force_on | (pwm_cnt < duty_g);
`else
  assign on = (&duty) | (pwm_cnt < duty);
`endif

endmodule

// File: rtl/led_pattern_driver.sv
// LED bank driver: off/solid/blink/chase/breathe patterns stepped by the divider's blink wave.
// Optional LED_GAMMA_EN (in led_pwm_gen) adds gamma-corrected PWM and one cycle of latency.
module led_pattern_driver
  import led_pkg::*;
#(
  parameter int NUM_LEDS     = 4,
  parameter int PWM_BITS     = 8,
  parameter int BREATHE_STEP = DEFAULT_BREATHE_STEP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                blink_in,
  input  logic [2:0]          mode,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                mode_load,
  output logic [NUM_LEDS-1:0] led,
  output logic                step_pulse
);

  localparam logic [PWM_BITS:0] STEP_W = (PWM_BITS+1)'(BREATHE_STEP);

  logic                blink_q;
  logic                step;
  mode_t               mode_q;
  logic [PWM_BITS-1:0] bright_q;
  logic                phase;
  logic [NUM_LEDS-1:0] chase;
  logic [PWM_BITS-1:0] level;
  logic                dir_up;
  logic [PWM_BITS-1:0] duty;
  logic                on;
  logic [NUM_LEDS-1:0] led_next;
  logic [PWM_BITS:0]   level_up;
  logic [PWM_BITS:0]   level_dn;
  logic                up_sat;
  logic                dn_sat;

  assign step     = blink_in & ~blink_q;
  assign level_up = {1'b0, level} + STEP_W;
  assign level_dn = {1'b0, level} - STEP_W;
  assign up_sat   = level_up >= {1'b0, bright_q};
  assign dn_sat   = {1'b0, level} <= STEP_W;

  // A load restarts every pattern and takes priority over a coincident step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q    <= 1'b1;
      step_pulse <= 1'b0;
      mode_q     <= MODE_OFF;
      bright_q   <= '0;
      phase      <= 1'b1;
      chase      <= NUM_LEDS'(1);
      level      <= '0;
      dir_up     <= 1'b1;
      led        <= '0;
    end else begin
      blink_q    <= blink_in;
      step_pulse <= step;
      led        <= led_next;
      if (mode_load) begin
        mode_q   <= decode_mode(mode);
        bright_q <= brightness;
        phase    <= 1'b1;
        chase    <= NUM_LEDS'(1);
        level    <= '0;
        dir_up   <= 1'b1;
      end else if (step) begin
        phase <= ~phase;
        chase <= {chase[NUM_LEDS-2:0], chase[NUM_LEDS-1]};
        if (dir_up) begin
          if (up_sat) begin
            level  <= bright_q;
            dir_up <= 1'b0;
          end else begin
            level <= level_up[PWM_BITS-1:0];
          end
        end else begin
          if (dn_sat) begin
            level  <= '0;
            dir_up <= 1'b1;
          end else begin
            level <= level_dn[PWM_BITS-1:0];
          end
        end
      end
    end
  end

  always_comb begin
    duty     = (mode_q == MODE_BREATHE) ? level : bright_q;
    led_next = '0;
    case (mode_q)
      MODE_SOLID:   led_next = {NUM_LEDS{on}};
      MODE_BLINK:   led_next = {NUM_LEDS{phase & on}};
      MODE_CHASE:   led_next = chase & {NUM_LEDS{on}};
      MODE_BREATHE: led_next = {NUM_LEDS{on}};
      default:      led_next = '0;
    endcase
  end

  led_pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk (clk),
    .rst (rst),
    .duty(duty),
    .on  (on)
  );

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed self-checking bench for led_pattern_driver (default build, linear PWM).
module tb_led_pattern_driver;

  localparam int NUM_LEDS = 4;
  localparam int PWM_BITS = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                blink_in;
  logic [2:0]          mode;
  logic [PWM_BITS-1:0] brightness;
  logic                mode_load;
  logic [NUM_LEDS-1:0] led;
  logic                step_pulse;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  led_pattern_driver #(
    .NUM_LEDS    (NUM_LEDS),
    .PWM_BITS    (PWM_BITS),
    .BREATHE_STEP(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .blink_in  (blink_in),
    .mode      (mode),
    .brightness(brightness),
    .mode_load (mode_load),
    .led       (led),
    .step_pulse(step_pulse)
  );

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expectValue(input string tag, input logic [31:0] value);
    exp_q.push_back(value);
    tag_q.push_back(tag);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    logic [31:0] expected;
    string       tag;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed %0d with nothing queued", observed);
      return;
    end
    expected = exp_q.pop_front();
    tag      = tag_q.pop_front();
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Optional rising edge on blink_in and/or a load strobe, landing on the same clock edge.
  task automatic applyStimulus(input bit load, input logic [2:0] m,
                               input logic [PWM_BITS-1:0] b, input bit rise);
    if (rise) begin
      blink_in = 1'b0;
      cycles(2);
      blink_in = 1'b1;
    end
    if (load) begin
      mode       = m;
      brightness = b;
      mode_load  = 1'b1;
    end
    cycles(1);
    mode_load = 1'b0;
    cycles(3);
  endtask

  task automatic countLed(input logic [NUM_LEDS-1:0] pattern, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (led === pattern) cnt++;
      cycles(1);
    end
  endtask

  initial begin
    int          cnt;
    logic [3:0]  chase_seq[5];
    int          breathe_seq[7];

    chase_seq   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    breathe_seq = '{16, 32, 40, 24, 8, 0, 16};

    rst        = 1'b1;
    blink_in   = 1'b1;
    mode       = 3'd0;
    brightness = '0;
    mode_load  = 1'b0;
    cycles(3);
    expectValue("reset_led", 0);
    checkOutput(32'(led));
    expectValue("reset_step_pulse", 0);
    checkOutput(32'(step_pulse));

    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (step_pulse === 1'b1) cnt++;
      cycles(1);
    end
    expectValue("no_spurious_step", 0);
    checkOutput(32'(cnt));

    blink_in = 1'b0;
    cycles(3);
    blink_in = 1'b1;
    cycles(1);
    expectValue("step_pulse_high", 1);
    checkOutput(32'(step_pulse));
    cycles(1);
    expectValue("step_pulse_one_cycle", 0);
    checkOutput(32'(step_pulse));
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (step_pulse === 1'b1) cnt++;
      cycles(1);
    end
    expectValue("step_pulse_no_repeat", 0);
    checkOutput(32'(cnt));

    applyStimulus(1'b1, 3'd1, 8'd64, 1'b0);
    countLed(4'hF, 256, cnt);
    expectValue("solid64_on_count", 64);
    checkOutput(32'(cnt));
    countLed(4'h0, 256, cnt);
    expectValue("solid64_off_count", 192);
    checkOutput(32'(cnt));

    applyStimulus(1'b1, 3'd1, 8'd255, 1'b0);
    countLed(4'hF, 256, cnt);
    expectValue("solid255_on_count", 256);
    checkOutput(32'(cnt));

    applyStimulus(1'b1, 3'd1, 8'd0, 1'b0);
    countLed(4'h0, 256, cnt);
    expectValue("solid0_off_count", 256);
    checkOutput(32'(cnt));

    applyStimulus(1'b1, 3'd3, 8'd255, 1'b0);
    expectValue("chase_after_load", 32'h1);
    checkOutput(32'(led));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 3'd0, 8'd0, 1'b1);
      expectValue($sformatf("chase_step%0d", i + 1), 32'(chase_seq[i]));
      checkOutput(32'(led));
    end

    applyStimulus(1'b1, 3'd4, 8'd40, 1'b0);
    countLed(4'hF, 256, cnt);
    expectValue("breathe_level0", 0);
    checkOutput(32'(cnt));
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 3'd0, 8'd0, 1'b1);
      countLed(4'hF, 256, cnt);
      expectValue($sformatf("breathe_step%0d", i + 1), 32'(breathe_seq[i]));
      checkOutput(32'(cnt));
    end

    applyStimulus(1'b1, 3'd2, 8'd255, 1'b0);
    expectValue("blink_after_load", 32'hF);
    checkOutput(32'(led));
    applyStimulus(1'b1, 3'd2, 8'd255, 1'b1);
    expectValue("blink_load_beats_step", 32'hF);
    checkOutput(32'(led));
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b1);
    expectValue("blink_next_step_off", 32'h0);
    checkOutput(32'(led));
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b1);
    expectValue("blink_step_on_again", 32'hF);
    checkOutput(32'(led));

    applyStimulus(1'b1, 3'd6, 8'd255, 1'b0);
    countLed(4'h0, 32, cnt);
    expectValue("mode6_off", 32);
    checkOutput(32'(cnt));

    applyStimulus(1'b1, 3'd3, 8'd255, 1'b0);
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b1);
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b1);
    expectValue("chase_before_reset", 32'h4);
    checkOutput(32'(led));
    rst = 1'b1;
    #1;
    expectValue("async_reset_led", 0);
    checkOutput(32'(led));
    @(negedge clk);
    rst = 1'b0;
    cycles(2);
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b1);
    countLed(4'h0, 32, cnt);
    expectValue("off_after_reset", 32);
    checkOutput(32'(cnt));

    expectValue("scoreboard_drained", 0);
    checkOutput(32'(exp_q.size() - 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
